// File: rtl/cache_ctrl_if.sv
// -----------------------------------------------------------------------------
// cache_ctrl_if
// Bundles the three buses the cache controller talks on:
//   CPU side   : cpu_addr, cpu_wr_rd, cpu_cs, cpu_din -> cpu_dout, cpu_rdy
//   SRAM side  : sram_addr, sram_din, sram_wen -> sram_dout (1-cycle latency)
//   SDRAM side : mem_addr, mem_wr_rd, mem_strb, mem_din -> mem_dout, mem_ack
// Modports:
//   slave  - the cache controller's own view (drives rdy/SRAM/SDRAM requests)
//   master - the surrounding environment (CPU, SRAM and SDRAM controller)
// -----------------------------------------------------------------------------
interface cache_ctrl_if;
    logic [15:0] cpu_addr;
    logic        cpu_wr_rd;
    logic        cpu_cs;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_rdy;

    logic [7:0]  sram_addr;
    logic [7:0]  sram_din;
    logic        sram_wen;
    logic [7:0]  sram_dout;

    logic [15:0] mem_addr;
    logic        mem_wr_rd;
    logic        mem_strb;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic        mem_ack;

    modport slave (
        input  cpu_addr, cpu_wr_rd, cpu_cs, cpu_din, sram_dout, mem_dout, mem_ack,
        output cpu_dout, cpu_rdy, sram_addr, sram_din, sram_wen,
               mem_addr, mem_wr_rd, mem_strb, mem_din
    );

    modport master (
        output cpu_addr, cpu_wr_rd, cpu_cs, cpu_din, sram_dout, mem_dout, mem_ack,
        input  cpu_dout, cpu_rdy, sram_addr, sram_din, sram_wen,
               mem_addr, mem_wr_rd, mem_strb, mem_din
    );
endinterface

// File: rtl/cache_ctrl.sv
// -----------------------------------------------------------------------------
// cache_ctrl
// Direct-mapped, write-back cache controller. Hits are served from an external
// byte-wide SRAM; misses write back a dirty victim line and refill the line
// through a byte-per-beat strobe/ack handshake to the SDRAM controller.
// Tag, valid and dirty bits are kept in internal registers.
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous, active-high reset
//   bus      - cache_ctrl_if.slave (CPU, SRAM and SDRAM buses)
//   hit_cnt  - (CACHE_STATS_EN only) saturating count of first-pass hits
//   miss_cnt - (CACHE_STATS_EN only) saturating count of first-pass misses
//
// Optional feature macro: CACHE_STATS_EN adds the hit/miss counters.
// -----------------------------------------------------------------------------
module cache_ctrl #(
    parameter int TAG_W = 8,
    parameter int IDX_W = 3,
    parameter int OFF_W = 5
) (
    input  logic          clk,
    input  logic          rst,
    cache_ctrl_if.slave   bus
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]   hit_cnt,
    output logic [15:0]   miss_cnt
`endif
);

    localparam int ADDR_W = TAG_W + IDX_W + OFF_W;
    localparam int LINES  = 1 << IDX_W;

    typedef enum logic [2:0] {
        IDLE, COMPARE, HIT_RD, HIT_WR, WB_RD, WB_XFER, FILL, DONE
    } state_t;

    state_t               state;
    logic                 cs_q;
    logic [TAG_W-1:0]     req_tag;
    logic [IDX_W-1:0]     req_idx;
    logic [OFF_W-1:0]     req_off;
    logic                 req_wr;
    logic [7:0]           req_data;
    logic [OFF_W-1:0]     k;
    logic [TAG_W-1:0]     tag_arr [LINES];
    logic [LINES-1:0]     valid;
    logic [LINES-1:0]     dirty;
`ifdef CACHE_STATS_EN
    logic                 first_pass;
`endif

    logic                 hit;
    logic                 last_beat;
    logic [OFF_W-1:0]     k_next;

    assign hit       = valid[req_idx] && (tag_arr[req_idx] == req_tag);
    assign last_beat = (k == '1);
    assign k_next    = k + 1'b1;

    // The whole controller is one registered FSM so every output is a flop.
    // The SRAM address is loaded at the acceptance edge so the read data is
    // already on sram_dout when HIT_RD samples it, giving rdy in cycle 3.
    // Each SDRAM beat raises mem_strb only after address/direction/data have
    // settled, and strb is dropped on the ack edge, guaranteeing a low gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cs_q          <= 1'b0;
            req_tag       <= '0;
            req_idx       <= '0;
            req_off       <= '0;
            req_wr        <= 1'b0;
            req_data      <= '0;
            k             <= '0;
            valid         <= '0;
            dirty         <= '0;
            for (int i = 0; i < LINES; i++) begin
                tag_arr[i] <= '0;
            end
            bus.cpu_dout  <= '0;
            bus.cpu_rdy   <= 1'b0;
            bus.sram_addr <= '0;
            bus.sram_din  <= '0;
            bus.sram_wen  <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wr_rd <= 1'b0;
            bus.mem_strb  <= 1'b0;
            bus.mem_din   <= '0;
`ifdef CACHE_STATS_EN
            first_pass    <= 1'b0;
            hit_cnt       <= '0;
            miss_cnt      <= '0;
`endif
        end else begin
            cs_q <= bus.cpu_cs;
            case (state)
                IDLE: begin
                    if (bus.cpu_cs && !cs_q) begin
                        req_tag       <= bus.cpu_addr[ADDR_W-1 -: TAG_W];
                        req_idx       <= bus.cpu_addr[OFF_W +: IDX_W];
                        req_off       <= bus.cpu_addr[OFF_W-1:0];
                        req_wr        <= bus.cpu_wr_rd;
                        req_data      <= bus.cpu_din;
                        bus.sram_addr <= bus.cpu_addr[IDX_W+OFF_W-1:0];
`ifdef CACHE_STATS_EN
                        first_pass    <= 1'b1;
`endif
                        state         <= COMPARE;
                    end
                end

                COMPARE: begin
                    k <= '0;
`ifdef CACHE_STATS_EN
                    first_pass <= 1'b0;
                    if (first_pass) begin
                        if (hit) begin
                            if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
                        end else begin
                            if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
                        end
                    end
`endif
                    if (hit) begin
                        bus.sram_addr <= {req_idx, req_off};
                        if (req_wr) begin
                            bus.sram_wen <= 1'b1;
                            bus.sram_din <= req_data;
                            state        <= HIT_WR;
                        end else begin
                            state        <= HIT_RD;
                        end
                    end else if (valid[req_idx] && dirty[req_idx]) begin
                        bus.sram_addr <= {req_idx, {OFF_W{1'b0}}};
                        state         <= WB_RD;
                    end else begin
                        state         <= FILL;
                    end
                end

                HIT_RD: begin
                    bus.cpu_dout <= bus.sram_dout;
                    bus.cpu_rdy  <= 1'b1;
                    state        <= DONE;
                end

                HIT_WR: begin
                    bus.sram_wen   <= 1'b0;
                    dirty[req_idx] <= 1'b1;
                    bus.cpu_rdy    <= 1'b1;
                    state          <= DONE;
                end

                // SRAM address for victim byte k is on the bus this cycle.
                WB_RD: begin
                    state <= WB_XFER;
                end

                // First cycle: victim byte is on sram_dout, launch the beat.
                // Later cycles: hold everything until the ack arrives.
                WB_XFER: begin
                    if (!bus.mem_strb) begin
                        bus.mem_din   <= bus.sram_dout;
                        bus.mem_addr  <= {tag_arr[req_idx], req_idx, k};
                        bus.mem_wr_rd <= 1'b1;
                        bus.mem_strb  <= 1'b1;
                    end else if (bus.mem_ack) begin
                        bus.mem_strb <= 1'b0;
                        if (last_beat) begin
                            k     <= '0;
                            state <= FILL;
                        end else begin
                            k             <= k_next;
                            bus.sram_addr <= {req_idx, k_next};
                            state         <= WB_RD;
                        end
                    end
                end

                // Three phases per beat: strobe pending, SRAM write of the
                // returned byte (strb low), then launch of the next beat or
                // commit of the line and re-compare.
                FILL: begin
                    if (bus.mem_strb) begin
                        if (bus.mem_ack) begin
                            bus.mem_strb  <= 1'b0;
                            bus.sram_wen  <= 1'b1;
                            bus.sram_din  <= bus.mem_dout;
                            bus.sram_addr <= {req_idx, k};
                        end
                    end else if (bus.sram_wen) begin
                        bus.sram_wen <= 1'b0;
                        if (last_beat) begin
                            tag_arr[req_idx] <= req_tag;
                            valid[req_idx]   <= 1'b1;
                            dirty[req_idx]   <= 1'b0;
                            bus.sram_addr    <= {req_idx, req_off};
                            state            <= COMPARE;
                        end else begin
                            k             <= k_next;
                            bus.mem_addr  <= {req_tag, req_idx, k_next};
                            bus.mem_wr_rd <= 1'b0;
                            bus.mem_strb  <= 1'b1;
                        end
                    end else begin
                        bus.mem_addr  <= {req_tag, req_idx, k};
                        bus.mem_wr_rd <= 1'b0;
                        bus.mem_strb  <= 1'b1;
                    end
                end

                DONE: begin
                    bus.cpu_rdy <= 1'b0;
                    state       <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_ctrl
// Drives CPU transactions into cache_ctrl, models the SRAM and an SDRAM
// responder with random ack latency, and checks the DUT against a line-level
// model of a direct-mapped write-back cache (tag/valid/dirty/data arrays plus
// a separate expected SDRAM image).
// -----------------------------------------------------------------------------
module tb_cache_ctrl;

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic [7:0]  data;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_ctrl_if bus();

`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    cache_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Real memories seen by the DUT
    logic [7:0] sram_mem [256];
    logic [7:0] sdram    [65536];

    // Behavioural cache model
    logic [7:0] sdram_model [65536];
    logic [7:0] m_data [256];
    logic [7:0] m_tag  [8];
    logic [7:0] m_valid;
    logic [7:0] m_dirty;
    int         m_hits;
    int         m_misses;

    // Expectations of the transaction in flight
    beat_t      exp_q[$];
    beat_t      obs_q[$];
    bit         txn_active;
    bit         done;
    int         cyc;
    int         exp_lat;
    bit         exp_rd;
    bit         exp_hit_wr;
    logic [7:0] exp_dout;
    logic [7:0] exp_wdata;
    logic [7:0] exp_sram_addr;
    logic [7:0] hold_dout;
    int         rdy_cyc;
    logic [7:0] rdy_dout;
    int         rdy_count;

    // Responder bookkeeping
    int         wait_cnt;
    int         rd_beats;
    int         wr_beats;
    bit         spurious_en;
    beat_t      rsp_b;

    // Monitor history for the strobe-stability check
    bit          prev_strb;
    logic [15:0] prev_addr;
    logic        prev_wr;
    logic [7:0]  prev_din;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Synchronous SRAM with one-cycle read latency
    always @(posedge clk) begin
        if (bus.sram_wen) sram_mem[bus.sram_addr] <= bus.sram_din;
        bus.sram_dout <= sram_mem[bus.sram_addr];
    end

    // SDRAM responder: acks each strobe after 0..2 idle cycles, records the
    // beat for the monitor, and optionally throws in acks while strb is low.
    always @(negedge clk) begin
        if (rst) begin
            bus.mem_ack = 1'b0;
            wait_cnt    = 0;
        end else if (bus.mem_ack) begin
            bus.mem_ack = 1'b0;
        end else if (bus.mem_strb) begin
            if (wait_cnt == 0) begin
                rsp_b.addr = bus.mem_addr;
                rsp_b.wr   = bus.mem_wr_rd;
                if (bus.mem_wr_rd) begin
                    rsp_b.data        = bus.mem_din;
                    sdram[bus.mem_addr] = bus.mem_din;
                    wr_beats++;
                end else begin
                    rsp_b.data   = sdram[bus.mem_addr];
                    bus.mem_dout = sdram[bus.mem_addr];
                    rd_beats++;
                end
                obs_q.push_back(rsp_b);
                bus.mem_ack = 1'b1;
                wait_cnt    = $urandom_range(0, 2);
            end else begin
                wait_cnt--;
            end
        end else if (spurious_en && ($urandom_range(0, 7) == 0)) begin
            bus.mem_ack  = 1'b1;
            bus.mem_dout = 8'($urandom);
        end
    end

    // Compare process: every cycle, check SDRAM beats against the expected
    // sequence, strobe stability, hit timing, read data and dout hold.
    always @(negedge clk) begin
        if (rst) begin
            prev_strb = 1'b0;
        end else begin
            while (obs_q.size() > 0) begin
                beat_t o;
                beat_t e;
                o = obs_q.pop_front();
                if (exp_q.size() == 0) begin
                    checkOutput("extra_beat_addr", {16'h0, o.addr}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("beat_addr", {16'h0, o.addr}, {16'h0, e.addr});
                    checkOutput("beat_dir", {31'h0, o.wr}, {31'h0, e.wr});
                    if (e.wr) checkOutput("wb_data", {24'h0, o.data}, {24'h0, e.data});
                end
            end

            if (prev_strb && bus.mem_strb) begin
                checkOutput("strb_stable", {7'h0, bus.mem_wr_rd, bus.mem_din, bus.mem_addr},
                            {7'h0, prev_wr, prev_din, prev_addr});
            end
            prev_strb = bus.mem_strb;
            prev_addr = bus.mem_addr;
            prev_wr   = bus.mem_wr_rd;
            prev_din  = bus.mem_din;

            if (txn_active && !done && exp_hit_wr) begin
                if (cyc == 2) begin
                    checkOutput("hitwr_wen", {31'h0, bus.sram_wen}, 32'h1);
                    checkOutput("hitwr_addr", {24'h0, bus.sram_addr}, {24'h0, exp_sram_addr});
                    checkOutput("hitwr_din", {24'h0, bus.sram_din}, {24'h0, exp_wdata});
                end else begin
                    checkOutput("hitwr_wen_idle", {31'h0, bus.sram_wen}, 32'h0);
                end
            end
            if (txn_active && !done && exp_lat == 3) begin
                checkOutput("hit_no_strb", {31'h0, bus.mem_strb}, 32'h0);
            end

            if (bus.cpu_rdy) begin
                rdy_count++;
                checkOutput("rdy_expected", {31'h0, txn_active && !done}, 32'h1);
                if (txn_active && !done) begin
                    if (exp_lat >= 0) checkOutput("hit_latency", cyc, exp_lat);
                    checkOutput("beats_pending", exp_q.size(), 0);
                    if (exp_rd) begin
                        checkOutput("read_data", {24'h0, bus.cpu_dout}, {24'h0, exp_dout});
                        hold_dout = exp_dout;
                    end else begin
                        checkOutput("write_dout_hold", {24'h0, bus.cpu_dout}, {24'h0, hold_dout});
                    end
`ifdef CACHE_STATS_EN
                    checkOutput("hit_cnt", {16'h0, hit_cnt}, m_hits);
                    checkOutput("miss_cnt", {16'h0, miss_cnt}, m_misses);
`endif
                    rdy_cyc  = cyc;
                    rdy_dout = bus.cpu_dout;
                    done     = 1'b1;
                end
            end else begin
                checkOutput("dout_hold", {24'h0, bus.cpu_dout}, {24'h0, hold_dout});
            end
        end
    end

    task automatic modelReset();
        m_valid   = '0;
        m_dirty   = '0;
        m_hits    = 0;
        m_misses  = 0;
        hold_dout = '0;
        for (int i = 0; i < 8; i++) m_tag[i] = '0;
    endtask

    // One CPU transaction. glitch_at > 0 re-pulses cs at that cycle;
    // reset_at_beat >= 0 asserts rst while that fill beat is in flight.
    task automatic applyStimulus(input logic [15:0] addr, input logic wr, input logic [7:0] din,
                                 input int glitch_at, input int reset_at_beat);
        logic [2:0] idx;
        logic [7:0] tg;
        logic [4:0] off;
        bit         hit;
        beat_t      b;
        int         rd_start;
        bit         was_reset;

        idx = addr[7:5];
        tg  = addr[15:8];
        off = addr[4:0];
        hit = m_valid[idx] && (m_tag[idx] == tg);
        if (!hit) begin
            if (m_valid[idx] && m_dirty[idx]) begin
                for (int j = 0; j < 32; j++) begin
                    b.addr = {m_tag[idx], idx, 5'(j)};
                    b.wr   = 1'b1;
                    b.data = m_data[{idx, 5'(j)}];
                    sdram_model[b.addr] = b.data;
                    exp_q.push_back(b);
                end
            end
            for (int j = 0; j < 32; j++) begin
                b.addr = {tg, idx, 5'(j)};
                b.wr   = 1'b0;
                b.data = 8'h00;
                m_data[{idx, 5'(j)}] = sdram_model[b.addr];
                exp_q.push_back(b);
            end
            m_tag[idx]   = tg;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_misses++;
        end else begin
            m_hits++;
        end
        if (wr) begin
            m_data[{idx, off}] = din;
            m_dirty[idx]       = 1'b1;
        end else begin
            exp_dout = m_data[{idx, off}];
        end
        exp_lat       = hit ? 3 : -1;
        exp_rd        = !wr;
        exp_hit_wr    = hit && wr;
        exp_wdata     = din;
        exp_sram_addr = {idx, off};

        @(posedge clk);
        #1;
        rd_start      = rd_beats;
        was_reset     = 1'b0;
        bus.cpu_addr  = addr;
        bus.cpu_wr_rd = wr;
        bus.cpu_din   = din;
        bus.cpu_cs    = 1'b1;
        cyc           = 0;
        done          = 1'b0;
        txn_active    = 1'b1;

        for (int t = 0; t < 3000 && !done && !was_reset; t++) begin
            @(posedge clk);
            cyc++;
            #1;
            if (glitch_at > 0 && cyc == glitch_at)     bus.cpu_cs = 1'b0;
            if (glitch_at > 0 && cyc == glitch_at + 2) bus.cpu_cs = 1'b1;
            if (reset_at_beat >= 0 && bus.mem_strb && (rd_beats - rd_start) == reset_at_beat) begin
                rst = 1'b1;
                #1;
                checkOutput("rst_strb", {31'h0, bus.mem_strb}, 32'h0);
                checkOutput("rst_rdy", {31'h0, bus.cpu_rdy}, 32'h0);
                checkOutput("rst_wen", {31'h0, bus.sram_wen}, 32'h0);
                bus.cpu_cs = 1'b0;
                txn_active = 1'b0;
                exp_q.delete();
                modelReset();
                repeat (2) @(posedge clk);
                #1;
                obs_q.delete();
                rst       = 1'b0;
                was_reset = 1'b1;
            end
        end
        if (!was_reset) begin
            if (!done) checkOutput("rdy_timeout", 32'h0, 32'h1);
            bus.cpu_cs = 1'b0;
            txn_active = 1'b0;
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r0;
        int w0;
        int c0;
        int m0;
        int bad;
        logic [7:0] tags [4];

        rst           = 1'b1;
        bus.cpu_addr  = '0;
        bus.cpu_wr_rd = 1'b0;
        bus.cpu_cs    = 1'b0;
        bus.cpu_din   = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_dout  = '0;
        txn_active    = 1'b0;
        done          = 1'b0;
        spurious_en   = 1'b0;
        rd_beats      = 0;
        wr_beats      = 0;
        rdy_count     = 0;
        prev_strb     = 1'b0;
        modelReset();
        for (int i = 0; i < 256; i++) begin
            sram_mem[i] = 8'($urandom);
            m_data[i]   = 8'h00;
        end
        for (int i = 0; i < 65536; i++) sdram[i] = 8'($urandom);
        sdram[16'h1100] = 8'h5A;
        for (int i = 0; i < 65536; i++) sdram_model[i] = sdram[i];

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rdy", {31'h0, bus.cpu_rdy}, 32'h0);
        checkOutput("reset_dout", {24'h0, bus.cpu_dout}, 32'h0);
        checkOutput("reset_strb", {31'h0, bus.mem_strb}, 32'h0);
        checkOutput("reset_wen", {31'h0, bus.sram_wen}, 32'h0);
        checkOutput("reset_mem_addr", {16'h0, bus.mem_addr}, 32'h0);
        checkOutput("reset_sram_addr", {24'h0, bus.sram_addr}, 32'h0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] clean read miss 0x1100");
        r0 = rd_beats; w0 = wr_beats;
        applyStimulus(16'h1100, 1'b0, 8'h00, 0, -1);
        checkOutput("t1_fill_beats", rd_beats - r0, 32);
        checkOutput("t1_wb_beats", wr_beats - w0, 0);
        checkOutput("t1_dout", {24'h0, rdy_dout}, 32'h5A);

        $display("[TB] write hit 0x1102 <= 0xBB");
        r0 = rd_beats; w0 = wr_beats;
        applyStimulus(16'h1102, 1'b1, 8'hBB, 0, -1);
        checkOutput("t2_latency", rdy_cyc, 3);
        checkOutput("t2_no_beats", (rd_beats - r0) + (wr_beats - w0), 0);

        $display("[TB] read hit 0x1102");
        applyStimulus(16'h1102, 1'b0, 8'h00, 0, -1);
        checkOutput("t3_latency", rdy_cyc, 3);
        checkOutput("t3_dout", {24'h0, rdy_dout}, 32'hBB);

        $display("[TB] dirty eviction by read 0x2200");
        r0 = rd_beats; w0 = wr_beats;
        applyStimulus(16'h2200, 1'b0, 8'h00, 0, -1);
        checkOutput("t4_wb_beats", wr_beats - w0, 32);
        checkOutput("t4_fill_beats", rd_beats - r0, 32);
        checkOutput("t4_wb_byte2", {24'h0, sdram[16'h1102]}, 32'hBB);
        checkOutput("t4_wb_byte0", {24'h0, sdram[16'h1100]}, 32'h5A);

        $display("[TB] second cs edge during fill");
        c0 = rdy_count;
`ifdef CACHE_STATS_EN
        m0 = int'(miss_cnt);
`else
        m0 = 0;
`endif
        applyStimulus(16'h3340, 1'b0, 8'h00, 20, -1);
        repeat (4) @(posedge clk);
        checkOutput("t5_one_rdy", rdy_count - c0, 1);
`ifdef CACHE_STATS_EN
        checkOutput("t5_miss_inc", int'(miss_cnt) - m0, 1);
`else
        if (m0 != 0) checkOutput("t5_stats_absent", m0, 0);
`endif

        $display("[TB] reset during fill beat 10");
        applyStimulus(16'h4460, 1'b0, 8'h00, 0, 10);
        r0 = rd_beats;
        applyStimulus(16'h4460, 1'b0, 8'h00, 0, -1);
        checkOutput("t6_refill_beats", rd_beats - r0, 32);

        $display("[TB] random traffic");
        spurious_en = 1'b1;
        tags[0] = 8'h11; tags[1] = 8'h22; tags[2] = 8'h33; tags[3] = 8'h44;
        for (int n = 0; n < 80; n++) begin
            logic [15:0] a;
            a = {tags[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 5'($urandom)};
            applyStimulus(a, 1'($urandom), 8'($urandom), 0, -1);
        end
        spurious_en = 1'b0;
        repeat (4) @(posedge clk);

        bad = 0;
        for (int i = 0; i < 65536; i++) if (sdram[i] !== sdram_model[i]) bad++;
        checkOutput("sdram_image", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
